// File: rtl/status_vector_sync_fifo_pkg.sv
// Shared constants for the 10G status FIFO: field offsets inside the
// concatenated status word {pcs_pma[447:0], mac[1:0], pcspma[7:0]}.
package status_fifo_pkg;

  localparam int STATUS_W    = 458;
  localparam int PCSPMA_LSB  = 0;
  localparam int PCSPMA_W    = 8;
  localparam int MAC_LSB     = 8;
  localparam int MAC_W       = 2;
  localparam int PCS_PMA_LSB = 10;

  typedef logic [STATUS_W-1:0] status_word_t;

endpackage

// File: rtl/status_vector_sync_fifo_if.sv
// Bus bundle between the status sources and the FIFO.
// Handshake: a write is taken on a rising edge when wr_en=1 and full=0,
// a read when rd_en=1 and empty=0; requests against full/empty are
// silently ignored. dout is valid the cycle after an accepted read.
// Optional macro STATUS_FIFO_DATA_COUNT_EN adds the data_count signal.
interface status_vector_sync_fifo_if
  import status_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = STATUS_W,
  parameter int DEPTH      = 16
);
  logic [DATA_WIDTH-1:0]           din;
  logic                            wr_en;
  logic                            rd_en;
  logic [DATA_WIDTH-1:0]           dout;
  logic                            full;
  logic                            empty;
  logic [DATA_WIDTH-PCS_PMA_LSB-1:0] pcs_pma_status_vector;
  logic [MAC_W-1:0]                mac_status_vector;
  logic [PCSPMA_W-1:0]             pcspma_status;
`ifdef STATUS_FIFO_DATA_COUNT_EN
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  logic [ADDR_WIDTH:0]             data_count;
`endif

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, empty, pcs_pma_status_vector, mac_status_vector, pcspma_status
`ifdef STATUS_FIFO_DATA_COUNT_EN
    , input data_count
`endif
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, empty, pcs_pma_status_vector, mac_status_vector, pcspma_status
`ifdef STATUS_FIFO_DATA_COUNT_EN
    , output data_count
`endif
  );

endinterface

// File: rtl/status_vector_sync_fifo_core.sv
// FIFO core: storage RAM, wrap-bit pointers, registered flags and dout.
// Optional macro STATUS_FIFO_DATA_COUNT_EN adds a registered occupancy count.
module status_fifo_core #(
  parameter int DATA_WIDTH = 458,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_rd_acc
`ifdef STATUS_FIFO_DATA_COUNT_EN
  , output logic [ADDR_WIDTH:0] o_data_count
`endif
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_full;
  logic                  r_empty;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_wptr_nxt;
  logic [ADDR_WIDTH:0]   w_rptr_nxt;
  logic                  w_full_nxt;
  logic                  w_empty_nxt;

  // Acceptance uses the registered flags, so a write at full is dropped
  // even when a read frees a slot in the same cycle.
  assign w_wr_acc    = i_wr_en & ~r_full;
  assign w_rd_acc    = i_rd_en & ~r_empty;
  assign w_wptr_nxt  = r_wptr + {{ADDR_WIDTH{1'b0}}, w_wr_acc};
  assign w_rptr_nxt  = r_rptr + {{ADDR_WIDTH{1'b0}}, w_rd_acc};
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt[ADDR_WIDTH] != w_rptr_nxt[ADDR_WIDTH]) &&
                       (w_wptr_nxt[ADDR_WIDTH-1:0] == w_rptr_nxt[ADDR_WIDTH-1:0]);

  // Storage write; the RAM is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= i_din;
  end

  // Pointers, flags and read data advance together on each edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_dout  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= w_full_nxt;
      r_empty <= w_empty_nxt;
      if (w_rd_acc) r_dout <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
    end
  end

`ifdef STATUS_FIFO_DATA_COUNT_EN
  logic [ADDR_WIDTH:0] r_data_count;

  // Occupancy tracks the next pointers so it changes with the flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_data_count <= '0;
    else          r_data_count <= w_wptr_nxt - w_rptr_nxt;
  end

  assign o_data_count = r_data_count;
`endif

  assign o_dout   = r_dout;
  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_rd_acc = w_rd_acc;

endmodule

// File: rtl/status_vector_sync_fifo.sv
// Status FIFO top: FIFO core plus the three held status fields that
// capture dout one cycle after it is loaded (two cycles after the read).
// Optional macro STATUS_FIFO_DATA_COUNT_EN exposes the core occupancy count.
module status_vector_sync_fifo
  import status_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = STATUS_W,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                     core_clk,
  input  logic                     core_resetn,
  status_vector_sync_fifo_if.slave bus
);

  logic [DATA_WIDTH-1:0]             w_dout;
  logic                              w_full;
  logic                              w_empty;
  logic                              w_rd_acc;
  logic                              r_rd_valid;
  logic [DATA_WIDTH-PCS_PMA_LSB-1:0] r_pcs_pma;
  logic [MAC_W-1:0]                  r_mac;
  logic [PCSPMA_W-1:0]               r_pcspma;
`ifdef STATUS_FIFO_DATA_COUNT_EN
  logic [ADDR_WIDTH:0]               w_data_count;
`endif

  status_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_core (
    .i_clk        (core_clk),
    .i_rst_n      (core_resetn),
    .i_din        (bus.din),
    .i_wr_en      (bus.wr_en),
    .i_rd_en      (bus.rd_en),
    .o_dout       (w_dout),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_rd_acc     (w_rd_acc)
`ifdef STATUS_FIFO_DATA_COUNT_EN
    , .o_data_count (w_data_count)
`endif
  );

  // Marks the cycle in which dout carries freshly read data.
  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) r_rd_valid <= 1'b0;
    else              r_rd_valid <= w_rd_acc;
  end

  // Split the fresh word into its fields; hold them otherwise.
  always_ff @(posedge core_clk or negedge core_resetn) begin
    if (!core_resetn) begin
      r_pcs_pma <= '0;
      r_mac     <= '0;
      r_pcspma  <= '0;
    end else if (r_rd_valid) begin
      r_pcs_pma <= w_dout[DATA_WIDTH-1:PCS_PMA_LSB];
      r_mac     <= w_dout[MAC_LSB +: MAC_W];
      r_pcspma  <= w_dout[PCSPMA_LSB +: PCSPMA_W];
    end
  end

  assign bus.dout                  = w_dout;
  assign bus.full                  = w_full;
  assign bus.empty                 = w_empty;
  assign bus.pcs_pma_status_vector = r_pcs_pma;
  assign bus.mac_status_vector     = r_mac;
  assign bus.pcspma_status         = r_pcspma;
`ifdef STATUS_FIFO_DATA_COUNT_EN
  assign bus.data_count            = w_data_count;
`endif

endmodule

// File: tb/tb_status_vector_sync_fifo.sv
// Directed bench for status_vector_sync_fifo: reset, single word, fill and
// drain, full/empty simultaneous access, wrapping stream, async reset.
module tb_status_vector_sync_fifo;
  import status_fifo_pkg::*;

  localparam int DW    = STATUS_W;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic core_clk = 1'b0;
  logic core_resetn;
  always #5 core_clk = ~core_clk;

  status_vector_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  status_vector_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .core_clk    (core_clk),
    .core_resetn (core_resetn),
    .bus         (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_fields(input string tag, input status_word_t w);
    check_eq({tag, "_pcspma"}, DW'(bus.pcspma_status), DW'(w[7:0]));
    check_eq({tag, "_mac"}, DW'(bus.mac_status_vector), DW'(w[9:8]));
    check_eq({tag, "_pcs_pma"}, DW'(bus.pcs_pma_status_vector), DW'(w[DW-1:10]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    bus.din   = w;
    bus.wr_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [DW-1:0] exp);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check_eq(tag, bus.dout, exp);
  endtask

  function automatic status_word_t make_word(input int i);
    status_word_t w;
    w = {448'(i + 1) * 448'h1_0000_0001, 2'(i), 8'(8'hC0 + i)};
    return w;
  endfunction

  // ---------------- stimulus ----------------
  status_word_t w_a5;
  status_word_t fld_model;
  status_word_t fld_word;
  logic         fld_pend;
  logic         rd_now;
  int           sent;
  int           got;
  int           cyc;

  initial begin
    core_resetn = 1'b0;
    bus.din     = '0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    #12;

    // Reset state
    check_eq("rst_empty", DW'(bus.empty), DW'(1));
    check_eq("rst_full", DW'(bus.full), DW'(0));
    check_eq("rst_dout", bus.dout, '0);
    check_fields("rst", '0);
`ifdef STATUS_FIFO_DATA_COUNT_EN
    check_eq("rst_count", DW'(bus.data_count), DW'(0));
`endif
    core_resetn = 1'b1;
    tick();

    // Single word, field split and latency
    w_a5 = {448'h1234, 2'b10, 8'hA5};
    write_word(w_a5);
    check_eq("a5_not_empty", DW'(bus.empty), DW'(0));
    read_expect("a5_dout", w_a5);
    check_fields("a5_early", '0);
    tick();
    check_fields("a5", w_a5);
    check_eq("a5_empty", DW'(bus.empty), DW'(1));

    // Fill to full, drop the extra write, drain in order
    for (int i = 0; i < DEPTH; i++) begin
      write_word(DW'(i));
      if (i == DEPTH - 2) check_eq("fill_not_full", DW'(bus.full), DW'(0));
    end
    check_eq("fill_full", DW'(bus.full), DW'(1));
`ifdef STATUS_FIFO_DATA_COUNT_EN
    check_eq("fill_count", DW'(bus.data_count), DW'(DEPTH));
`endif
    write_word(DW'(8'hFF));
    check_eq("drop_full", DW'(bus.full), DW'(1));
    for (int i = 0; i < DEPTH; i++) read_expect("drain", DW'(i));
    check_eq("drain_empty", DW'(bus.empty), DW'(1));
    read_expect("rd_empty_hold", DW'(15));

    // Full with simultaneous read and write
    for (int i = 0; i < DEPTH; i++) write_word(DW'(i));
    bus.din   = DW'(8'hFF);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_eq("full_rw_dout", bus.dout, DW'(0));
    check_eq("full_rw_full", DW'(bus.full), DW'(0));
`ifdef STATUS_FIFO_DATA_COUNT_EN
    check_eq("full_rw_count", DW'(bus.data_count), DW'(DEPTH - 1));
`endif
    for (int i = 1; i < DEPTH; i++) read_expect("full_rw_drain", DW'(i));
    check_eq("full_rw_empty", DW'(bus.empty), DW'(1));

    // Empty with simultaneous read and write
    bus.din   = DW'(8'h77);
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_eq("empty_rw_empty", DW'(bus.empty), DW'(0));
    check_eq("empty_rw_dout", bus.dout, DW'(15));
    read_expect("empty_rw_read", DW'(8'h77));
    check_eq("empty_rw_after", DW'(bus.empty), DW'(1));
    tick();
    check_fields("f77", DW'(8'h77));

    // Continuous stream of 40 words through the wrapping pointers
    fld_model = DW'(8'h77);
    fld_pend  = 1'b0;
    fld_word  = '0;
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 40 && cyc < 400) begin
      bus.wr_en = !bus.full && (sent < 40);
      bus.din   = make_word(sent);
      if (bus.wr_en) begin
        exp_q.push_back(make_word(sent));
        sent++;
      end
      rd_now    = !bus.empty;
      bus.rd_en = rd_now;
      tick();
      cyc++;
      if (fld_pend) fld_model = fld_word;
      fld_pend = 1'b0;
      if (rd_now) begin
        if (exp_q.size() > 0) begin
          fld_word = exp_q.pop_front();
          check_eq("stream_dout", bus.dout, fld_word);
          fld_pend = 1'b1;
        end
        got++;
      end
      check_fields("stream", fld_model);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_eq("stream_count", DW'(got), DW'(40));
    tick();
    if (fld_pend) fld_model = fld_word;
    check_fields("stream_last", fld_model);

    // Asynchronous reset in the middle of traffic
    write_word(make_word(50));
    write_word(make_word(51));
    #2;
    core_resetn = 1'b0;
    #1;
    check_eq("arst_empty", DW'(bus.empty), DW'(1));
    check_eq("arst_full", DW'(bus.full), DW'(0));
    check_eq("arst_dout", bus.dout, '0);
    check_fields("arst", '0);
    #3;
    core_resetn = 1'b1;
    tick();
    check_eq("arst_still_empty", DW'(bus.empty), DW'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/status_vector_sync_fifo.md
Name: status_vector_sync_fifo

Overview:
Single-clock FIFO for the 10G interface status path. It buffers the 458-bit concatenated status word: pcs_pma status (448 bits), MAC status (2 bits) and pcspma status (8 bits). Behind the FIFO read port it holds the last-read word, split into three field registers. It sits between the MAC/PCS status sources and the core_clk register file.

Parameters:
DATA_WIDTH, 458, width of din/dout; must be at least 11.
DEPTH, 16, number of entries; power of two, at least 2.
ADDR_WIDTH, $clog2(DEPTH), address width; pointers are ADDR_WIDTH+1 bits.

Ports:
core_clk  in  1  sole clock; all logic is rising-edge.
core_resetn  in  1  asynchronous, active-low reset.
din  in  DATA_WIDTH  write data, bit layout {pcs_pma[447:0], mac[1:0], pcspma[7:0]}.
wr_en  in  1  write request.
rd_en  in  1  read request.
dout  out  DATA_WIDTH  read data (registered).
full  out  1  FIFO holds DEPTH entries.
empty  out  1  FIFO holds 0 entries.
pcs_pma_status_vector  out  DATA_WIDTH-10  held field dout[DATA_WIDTH-1:10].
mac_status_vector  out  2  held field dout[9:8].
pcspma_status  out  8  held field dout[7:0].

Behaviour:
- Reset (core_resetn=0, asynchronous):
  - write and read pointers cleared to 0.
  - empty=1, full=0, dout=0.
  - all three held status outputs = 0; rd_valid flag = 0.
  - Storage RAM is not reset.
- Write acceptance:
  - A write is accepted when wr_en=1 and full=0.
  - On acceptance, mem[wptr] <= din and wptr increments.
  - A write while full is dropped, with no error flag.
- Read acceptance:
  - A read is accepted when rd_en=1 and empty=0.
  - On acceptance, dout <= mem[rptr] at that same edge, so dout is valid in the cycle after the request (latency 1, standard non-FWFT mode), and rptr increments.
  - dout holds its value when no read is accepted.
  - A read while empty is ignored and dout is unchanged.
- Simultaneous wr_en and rd_en:
  - When neither full nor empty, both are accepted and the occupancy is unchanged.
  - When empty, only the write is accepted.
  - When full, only the read is accepted; the write is dropped even though a slot frees that cycle.
- Flags:
  - Registered, and updated on the same edge as the pointers.
  - empty = (wptr == rptr).
  - full = (MSBs differ) and (lower ADDR_WIDTH bits equal).
  - Pointers wrap modulo 2*DEPTH; the address is the lower ADDR_WIDTH bits.
- Held status registers:
  - rd_valid <= (read accepted), each cycle.
  - When rd_valid=1, the three outputs load their fields from dout; otherwise they hold.
  - Net latency from an accepted read to the field update is 2 cycles.
- Continuous-drain usage (wr_en=!full, rd_en=!empty): a word written at edge N sets empty=0 after N, is read at N+1, appears on dout after N+1, and reaches the fields after N+2.
- Reset mid-operation: contents are discarded, the FIFO is empty, and the fields return to 0 at once.

Optional Feature:
Macro STATUS_FIFO_DATA_COUNT_EN.
- When defined: adds output data_count [ADDR_WIDTH:0], registered, equal to wptr-rptr (0..DEPTH). It is updated on the same edge as the flags and is 0 at reset.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package status_fifo_pkg holds the field-offset constants and the status word typedef:
  - PCSPMA_LSB=0, PCSPMA_W=8.
  - MAC_LSB=8, MAC_W=2.
  - PCS_PMA_LSB=10.
- One sub-module, status_fifo_core, contains the RAM, pointers, flags and dout. The top level adds rd_valid and the three field registers.

Test Plan:
- Reset -> empty=1, full=0, dout=0, and all fields 0; asserting reset mid-traffic clears them asynchronously, without waiting for a clock edge.
- Write 0x...A5 (pcspma=0xA5, mac=2'b10, pcs_pma=0x1234), then read -> dout matches 1 cycle after rd_en; 1 further cycle later pcspma_status=0xA5, mac_status_vector=2'b10, pcs_pma_status_vector=0x1234.
- Write 16 words with values 0..15 -> full=1 after the 16th; a 17th write of 0xFF is dropped; draining gives 0..15 in order, then empty=1; an extra rd_en leaves dout=15.
- Full, with wr_en and rd_en held together for one cycle -> read returns 0, the write is dropped, full=0 and occupancy is 15.
- Empty, with wr_en and rd_en held together -> only the write is accepted; empty=0 next cycle and dout is unchanged.
- Continuous drain of 40 words (pointer wrap) -> every word arrives in order, and the fields update exactly 2 cycles after each read.
